// File: rtl/hex_glyph_streamer_pkg.sv
// Shared definitions for the hex glyph raster streamer: glyph geometry,
// controller states, frame marker bundle and the leading-zero blank mask.
package hex_glyph_streamer_pkg;

   localparam int unsigned GLYPH_W    = 16;
   localparam int unsigned GLYPH_H    = 16;
   localparam int unsigned ROW_W      = 4;
   localparam int unsigned MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } marker_t;

   // Digit i blanks when it and every more-significant digit are zero; digit 0 never blanks.
   function automatic logic [MAX_DIGITS-1:0] blank_mask(
      input logic [4*MAX_DIGITS-1:0] v,
      input int unsigned             ndigits,
      input bit                      lz
   );
      logic [MAX_DIGITS-1:0] m;
      logic                  upper_zero;
      m          = '0;
      upper_zero = 1'b1;
      for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
         if (i < ndigits) begin
            upper_zero = upper_zero & (v[4*i +: 4] == 4'd0);
            m[i]       = lz & upper_zero;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/hex_glyph_raster_ctr.sv
// Column/row raster position for one frame; advances once per loaded pixel
// and wraps back to (0,0) after the last pixel so the next frame starts clean.
module hex_glyph_raster_ctr
   import hex_glyph_streamer_pkg::*;
#(
   parameter int unsigned NDIGITS = 4,
   parameter int unsigned COL_W   = $clog2(NDIGITS * GLYPH_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             col_last_c,
   output logic             frame_last_c
);

   localparam int unsigned COL_MAX = NDIGITS * GLYPH_W - 1;

   assign col_last_c   = (col == COL_W'(COL_MAX));
   assign frame_last_c = col_last_c && (row == ROW_W'(GLYPH_H - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_last_c) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/hex_glyph_streamer.sv
// Renders a latched NDIGITS-wide hex value as a row-major pixel stream by
// walking the external glyph ROM and registering each pixel onto valid/ready.
module hex_glyph_streamer
   import hex_glyph_streamer_pkg::*;
#(
   parameter int unsigned NDIGITS  = 4,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NDIGITS-1:0] value,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           font_x,
   output logic [3:0]           font_y,
   output logic [3:0]           font_digit,
   input  logic                 font_pixel,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 pix_data,
   output logic                 pix_sof,
   output logic                 pix_eol,
   output logic                 pix_eof
);

   localparam int unsigned COL_W = $clog2(NDIGITS * GLYPH_W);

   state_t                  state;
   logic [4*NDIGITS-1:0]    cap_value;
   logic [MAX_DIGITS-1:0]   blank;
   marker_t                 mark;

   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic                    col_last_c;
   logic                    frame_last_c;
   logic                    load_c;
   logic [2:0]              sel_c;
   logic [3:0]              nibble_c;
   marker_t                 mark_c;

   // Output register accepts a new pixel whenever it is empty or being drained.
   assign load_c   = (state == RUN) && (!pix_valid || pix_ready);

   // Column 0 is the most-significant digit.
   assign sel_c    = 3'(NDIGITS - 1) - 3'(col >> 4);
   assign nibble_c = 4'(cap_value >> {sel_c, 2'b00});

   assign mark_c.sof = (col == '0) && (row == '0);
   assign mark_c.eol = col_last_c;
   assign mark_c.eof = frame_last_c;

   hex_glyph_raster_ctr #(
      .NDIGITS (NDIGITS),
      .COL_W   (COL_W)
   ) u_ctr (
      .clk          (clk),
      .rst          (rst),
      .en           (load_c),
      .col          (col),
      .row          (row),
      .col_last_c   (col_last_c),
      .frame_last_c (frame_last_c)
   );

   // ROM lookup is quiet outside RUN so the glyph bus idles at zero.
   always_comb begin
      font_x     = '0;
      font_y     = '0;
      font_digit = '0;
      if (state == RUN) begin
         font_x     = col[3:0];
         font_y     = row;
         font_digit = nibble_c;
      end
   end

   assign pix_sof = mark.sof;
   assign pix_eol = mark.eol;
   assign pix_eof = mark.eof;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cap_value <= '0;
         blank     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pix_valid <= 1'b0;
         pix_data  <= 1'b0;
         mark      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cap_value <= value;
                  blank     <= blank_mask(32'(value), NDIGITS, BLANK_LZ);
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (load_c) begin
                  pix_valid <= 1'b1;
                  pix_data  <= font_pixel & ~blank[sel_c];
                  mark      <= mark_c;
                  if (frame_last_c) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Last pixel is held until the sink takes it.
               if (pix_ready) begin
                  pix_valid <= 1'b0;
                  pix_data  <= 1'b0;
                  mark      <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hex_glyph_streamer.sv
// Bench for hex_glyph_streamer: two instances (leading-zero blanking on/off)
// share stimulus and are compared against a frame-level pixel model.
module tb_hex_glyph_streamer;

   localparam int unsigned ND   = 4;
   localparam int unsigned FW   = ND * 16;
   localparam int unsigned NPIX = ND * 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] value;
   logic        pix_ready;

   logic       busy0, done0, fp0, pv0, pd0, sof0, eol0, eof0;
   logic [3:0] fx0, fy0, fd0;
   logic       busy1, done1, fp1, pv1, pd1, sof1, eol1, eof1;
   logic [3:0] fx1, fy1, fd1;

   logic [15:0] font [16][16];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Glyph ROM: row word MSB is the leftmost pixel.
   assign fp0 = font[fd0][fy0][4'd15 - fx0];
   assign fp1 = font[fd1][fy1][4'd15 - fx1];

   hex_glyph_streamer #(.NDIGITS(ND), .BLANK_LZ(1'b1)) dut0 (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy0), .done(done0),
      .font_x(fx0), .font_y(fy0), .font_digit(fd0), .font_pixel(fp0),
      .pix_valid(pv0), .pix_ready(pix_ready), .pix_data(pd0),
      .pix_sof(sof0), .pix_eol(eol0), .pix_eof(eof0)
   );

   hex_glyph_streamer #(.NDIGITS(ND), .BLANK_LZ(1'b0)) dut1 (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy1), .done(done1),
      .font_x(fx1), .font_y(fy1), .font_digit(fd1), .font_pixel(fp1),
      .pix_valid(pv1), .pix_ready(pix_ready), .pix_data(pd1),
      .pix_sof(sof1), .pix_eol(eol1), .pix_eof(eof1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Expected {data, sof, eol, eof} for pixel p of a frame showing v.
   function automatic logic [3:0] model_pix(input logic [15:0] v, input bit lz, input int p);
      int          col;
      int          pos;
      logic [15:0] upper;
      logic [3:0]  nib;
      logic [3:0]  r4;
      logic [3:0]  x4;
      logic        blank;
      logic        d;
      col   = p % FW;
      pos   = ND - 1 - col / 16;
      upper = v >> (4 * pos);
      nib   = upper[3:0];
      r4    = 4'(p / FW);
      x4    = 4'(col % 16);
      blank = lz && (pos != 0) && (upper == 16'd0);
      d     = blank ? 1'b0 : font[nib][r4][4'd15 - x4];
      return {d, p == 0, col == FW - 1, p == NPIX - 1};
   endfunction

   // Runs one frame starting at the current falling edge; restart_at / reset_at
   // (pixel counts, 0 = off) inject an ignored start or an asynchronous reset.
   task automatic run_frame(input logic [15:0] v, input int unsigned rdy_pct,
                            input int restart_at, input int reset_at,
                            output int ones_left, output logic [15:0] row2_line);
      int          cnt, bad0, bad1, stall_bad, gaps, last_at, done_n;
      bit          fin, prev_stall;
      logic [3:0]  m;
      logic [16:0] snap, cur;
      cnt = 0; bad0 = 0; bad1 = 0; stall_bad = 0; gaps = 0; last_at = -1; done_n = 0;
      fin = 1'b0; prev_stall = 1'b0; snap = '0; ones_left = 0; row2_line = '0;

      start = 1'b1; value = v; pix_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      value = 16'($urandom);
      check("busy_after_start", 32'(busy0), 32'd1);
      check("valid_latency_c1", 32'(pv0), 32'd0);

      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         cur = {pv0, pd0, sof0, eol0, eof0, fx0, fy0, fd0};
         if (prev_stall && cur !== snap) stall_bad++;
         if (cyc == 0) check("valid_latency_c2", 32'(pv0), 32'd1);
         if (done0) begin
            check("done_timing", 32'(cyc), 32'(last_at + 1));
            check("busy_at_done", 32'(busy0), 32'd0);
            check("done_lockstep", 32'(done1), 32'd1);
            fin = 1'b1;
         end else begin
            pix_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            if (pv0 && pix_ready) begin
               m = model_pix(v, 1'b1, cnt);
               if ({pd0, sof0, eol0, eof0} !== m) bad0++;
               m = model_pix(v, 1'b0, cnt);
               if ({pd1, sof1, eol1, eof1} !== m || !pv1) bad1++;
               if ((cnt % FW) < 32 && pd0) ones_left++;
               if (cnt >= 2 * FW && cnt < 2 * FW + 16) row2_line = {row2_line[14:0], pd0};
               if (cnt == NPIX - 1) last_at = cyc;
               cnt++;
            end else if (cnt > 0 && cnt < NPIX && !pv0) begin
               gaps++;
            end
            prev_stall = pv0 && !pix_ready;
            snap       = cur;
            if (restart_at > 0 && cnt == restart_at) begin
               start = 1'b1;
               value = 16'hFFFF;
            end
            if (reset_at > 0 && cnt == reset_at) begin
               #1 rst = 1'b1;
               #1;
               check("rst_async_outputs", 32'({pv0, pv1, busy0, busy1, pd0, sof0, eol0, eof0}), 32'd0);
               check("rst_async_font", 32'({fx0, fy0, fd0}), 32'd0);
               repeat (4) begin
                  @(negedge clk);
                  if (done0 || done1) done_n++;
               end
               check("no_done_after_rst", 32'(done_n), 32'd0);
               rst = 1'b0;
               return;
            end
         end
      end

      check("frame_done_seen", 32'(fin), 32'd1);
      check("pix_count", 32'(cnt), 32'(NPIX));
      check("stream_blank_lz", 32'(bad0), 32'd0);
      check("stream_no_blank", 32'(bad1), 32'd0);
      check("stall_stable", 32'(stall_bad), 32'd0);
      if (rdy_pct >= 100) check("valid_no_gaps", 32'(gaps), 32'd0);
   endtask

   initial begin
      int          ones;
      logic [15:0] line;
      logic [15:0] rv;

      rst = 1'b1; start = 1'b0; value = '0; pix_ready = 1'b0;
      for (int d = 0; d < 16; d++) begin
         for (int y = 0; y < 16; y++) begin
            font[d][y] = 16'($urandom);
            if (font[d][y] == 16'd0) font[d][y] = 16'h8001;
         end
      end
      font[1][2] = 16'b0011111110000000;

      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({pv0, busy0, done0, pd0, sof0, eol0, eof0}), 32'd0);
      check("reset_font", 32'({fx0, fy0, fd0}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_frame(16'h1234, 100, 0, 0, ones, line);
      check("row2_digit1_glyph", 32'(line), 32'h3F80);
      // Back-to-back frames also start in the done cycle.
      run_frame(16'h00A0, 100, 0, 0, ones, line);
      check("blank_cols_00A0", 32'(ones), 32'd0);
      run_frame(16'h0000, 100, 0, 0, ones, line);
      check("blank_cols_0000", 32'(ones), 32'd0);
      run_frame(16'h1234, 30, 0, 0, ones, line);
      run_frame(16'h1234, 100, 100, 0, ones, line);
      run_frame(16'h5678, 100, 0, 500, ones, line);
      run_frame(16'h1234, 100, 0, 0, ones, line);
      run_frame(16'h0F00, 30, 0, 0, ones, line);

      for (int i = 0; i < 3; i++) begin
         rv = 16'($urandom);
         if ($urandom_range(1) == 1) rv[15:8] = 8'h00;
         run_frame(rv, (i == 1) ? 100 : 30, 0, 0, ones, line);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
